fetch_loader_ctrl: RTL and testbench
====================================

Name: fetch_loader_ctrl

Overview:
Debug/load controller that sequences the fetch stage. It receives command and data bytes from the UART receiver, assembles 32-bit instructions and writes them into instruction memory through the fetch stage's program-write port. After loading, it drives the fetch stage's step enable, either continuously (RUN) or one cycle per command (STEP), until the pipeline reports halt. It sits between the UART RX block and the fetch stage.

Parameters:
DATA_W, 32, instruction width; must be 4 bytes
ADDR_W, 8, instruction memory address width
HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates a load

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
i_rx_data  in  8  received UART byte
i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle
i_halted  in  1  pipeline has retired the halt instruction; level signal
o_program_memory_write  out  1  instruction memory write enable, one-cycle pulse
o_instruction_write  out  DATA_W  word to write
o_address_write  out  ADDR_W  write address
o_step  out  1  fetch/pipeline advance enable
o_state  out  2  0 IDLE, 1 LOAD, 2 RUN, 3 STEP
o_load_error  out  1  sticky; memory filled without HALT_WORD

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, byte counter 0, address counter 0, assembly register 0.
- All outputs are registered. Bytes are consumed only on cycles with i_rx_valid=1.
- IDLE:
  - 0x4C 'L' -> LOAD. Clears the address counter, byte counter and o_load_error.
  - 0x43 'C' -> RUN.
  - 0x53 'S' -> STEP.
  - Any other byte is ignored.
- LOAD:
  - Each byte shifts into the assembly register, little-endian: 1st byte -> [7:0], 4th byte -> [31:24].
  - The byte counter wraps 3->0 on the 4th byte.
  - 4th byte accepted at edge t: on the cycle after t, o_program_memory_write=1, o_instruction_write=the assembled word, o_address_write=the current address. The write lasts exactly one cycle; the address increments at that same edge (address after the write = old address + 1).
  - If the word equals HALT_WORD, it is still written, then the state returns to IDLE.
  - If the write targets address 2^ADDR_W-1 and the word is not HALT_WORD: set o_load_error=1, return to IDLE, and leave the address counter wrapped to 0. No write ever goes past the top address.
  - Command letters are treated as data in LOAD.
- RUN:
  - o_step=1 every cycle.
  - When i_halted=1 is sampled: o_step=0 from the next cycle and the state returns to IDLE.
  - Bytes are ignored.
- STEP:
  - 0x4E 'N' -> o_step=1 for exactly one cycle, on the cycle after the strobe.
  - 0x45 'E' -> IDLE.
  - i_halted=1 -> IDLE, no further steps.
  - If i_halted and an 'N' strobe occur in the same cycle, halt wins and no step pulse is issued.
- Back-to-back byte strobes on consecutive cycles must be handled without loss.
- Reset asserted mid-load aborts the load immediately. Any partial word is discarded, and a pending write pulse is cancelled.
- o_program_memory_write and o_step are never high in the same cycle.

Test Plan:
- Reset: hold rst=0 with random inputs -> every output 0, o_state=0; release -> still IDLE.
- Load: 'L' followed by bytes 13,00,21,20 then FF,FF,FF,FF.
  - One write pulse: addr 0, data 0x20210013.
  - Then a write pulse at addr 1, data 0xFFFFFFFF.
  - o_state returns to 0; total of 2 write pulses; o_load_error=0.
- Overflow: 'L' then 256 non-halt words (1024 bytes) -> 256 writes at addresses 0..255, then o_load_error=1 and IDLE. A second 'L' clears o_load_error.
- RUN: 'C', then i_halted=1 ten cycles later -> o_step high for those 10 cycles and low from the cycle after i_halted is sampled; o_state returns to 0.
- STEP: 'S', then 'N','N','N' with gaps, then 'E' -> exactly 3 single-cycle o_step pulses, each one cycle after its strobe; o_state returns to 0. A separate case with i_halted coinciding with an 'N' strobe -> no pulse, IDLE.
- Reset mid-load: 'L', 0xAA, 0xBB, assert rst=0, release, then 'L' plus 4 bytes 01,02,03,04 -> write at addr 0 with data 0x04030201 (no stale bytes carried over).

Source files
------------

// File: rtl/fetch_loader_ctrl.sv
// fetch_loader_ctrl: UART-driven loader that fills instruction memory, then runs or single-steps fetch.
module fetch_loader_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_halted,
  output logic              o_program_memory_write,
  output logic [DATA_W-1:0] o_instruction_write,
  output logic [ADDR_W-1:0] o_address_write,
  output logic              o_step,
  output logic [1:0]        o_state,
  output logic              o_load_error
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, STEP} state_t;
  state_t state, state_d;
  logic [1:0] cnt, cnt_d;
  logic [ADDR_W-1:0] addr, addr_d, waddr_d;
  logic [DATA_W-1:0] sh_q, sh_d, instr_d, word;
  logic wr_d, step_d, err_d;
  assign word = {i_rx_data, sh_q[DATA_W-1:8]};
  assign o_state = state;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      sh_q <= '0;
      o_program_memory_write <= 1'b0;
      o_instruction_write <= '0;
      o_address_write <= '0;
      o_step <= 1'b0;
      o_load_error <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      addr <= addr_d;
      sh_q <= sh_d;
      o_program_memory_write <= wr_d;
      o_instruction_write <= instr_d;
      o_address_write <= waddr_d;
      o_step <= step_d;
      o_load_error <= err_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    addr_d = addr;
    sh_d = sh_q;
    wr_d = 1'b0;
    step_d = 1'b0;
    err_d = o_load_error;
    instr_d = o_instruction_write;
    waddr_d = o_address_write;
    case (state)
      IDLE: if (i_rx_valid) begin
        if (i_rx_data == 8'h4C) begin
          state_d = LOAD;
          cnt_d = '0;
          addr_d = '0;
          sh_d = '0;
          err_d = 1'b0;
        end else if (i_rx_data == 8'h43) begin
          state_d = RUN;
          step_d = 1'b1;
        end else if (i_rx_data == 8'h53) state_d = STEP;
      end
      LOAD: if (i_rx_valid) begin
        sh_d = word;
        cnt_d = cnt + 2'd1;
        if (cnt == 2'd3) begin
          wr_d = 1'b1;
          instr_d = word;
          waddr_d = addr;
          addr_d = addr + ADDR_W'(1);
          // A non-halt word landing in the top slot means memory is full without a terminator.
          if (word == HALT_WORD) state_d = IDLE;
          else if (&addr) begin
            err_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RUN: if (i_halted) state_d = IDLE; else step_d = 1'b1;
      STEP: if (i_halted) state_d = IDLE;
        else if (i_rx_valid && i_rx_data == 8'h4E) step_d = 1'b1;
        else if (i_rx_valid && i_rx_data == 8'h45) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fetch_loader_ctrl.sv
// tb_fetch_loader_ctrl: directed self-checking bench for the loader/run/step controller.
module tb_fetch_loader_ctrl;
  logic clk = 1'b0, rst = 1'b0, rx_valid = 1'b0, halted = 1'b0;
  logic [7:0] rx_data = '0;
  logic pmw, step, lerr;
  logic [31:0] instr;
  logic [7:0] waddr;
  logic [1:0] st;
  int vectors = 0, miscompares = 0;
  int wr_cnt = 0, step_cnt = 0, both_cnt = 0, base;

  fetch_loader_ctrl dut (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_halted(halted),
    .o_program_memory_write(pmw), .o_instruction_write(instr), .o_address_write(waddr),
    .o_step(step), .o_state(st), .o_load_error(lerr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pmw) wr_cnt++;
    if (step) step_cnt++;
    if (pmw && step) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled by the following posedge and
  // the task returns at the next negedge, where that edge's outputs are visible.
  task automatic push(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    repeat (5) begin
      @(negedge clk);
      rx_data = 8'($urandom);
      rx_valid = 1'($urandom);
      halted = 1'($urandom);
    end
    #1;
    chk("rst_pmw", 32'(pmw), 0);
    chk("rst_instr", instr, 0);
    chk("rst_addr", 32'(waddr), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_state", 32'(st), 0);
    chk("rst_err", 32'(lerr), 0);
    @(negedge clk);
    rx_valid = 0; halted = 0; rx_data = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_state", 32'(st), 0);

    base = wr_cnt;
    push(8'h4C);
    chk("load_state", 32'(st), 1);
    push(8'h13); push(8'h00); push(8'h21);
    chk("load_nowrite", 32'(pmw), 0);
    push(8'h20);
    chk("w0_pmw", 32'(pmw), 1);
    chk("w0_data", instr, 32'h2021_0013);
    chk("w0_addr", 32'(waddr), 0);
    push(8'hFF);
    chk("w0_oneshot", 32'(pmw), 0);
    push(8'hFF); push(8'hFF); push(8'hFF);
    chk("w1_pmw", 32'(pmw), 1);
    chk("w1_data", instr, 32'hFFFF_FFFF);
    chk("w1_addr", 32'(waddr), 1);
    chk("w1_state", 32'(st), 0);
    chk("w1_err", 32'(lerr), 0);
    repeat (2) @(negedge clk);
    chk("load_wr_count", 32'(wr_cnt - base), 2);

    base = wr_cnt;
    push(8'h4C);
    for (int i = 0; i < 256; i++) begin
      push(8'(i)); push(8'h01); push(8'h02); push(8'h03);
      chk("ovf_pmw", 32'(pmw), 1);
      chk("ovf_addr", 32'(waddr), 32'(i));
      chk("ovf_data", instr, {24'h030201, 8'(i)});
    end
    chk("ovf_err", 32'(lerr), 1);
    chk("ovf_state", 32'(st), 0);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (2) @(negedge clk);
    chk("ovf_wr_count", 32'(wr_cnt - base), 256);
    push(8'h4C);
    chk("relod_err_clr", 32'(lerr), 0);
    chk("reload_state", 32'(st), 1);
    push(8'hFF); push(8'hFF); push(8'hFF); push(8'hFF);
    chk("reload_addr", 32'(waddr), 0);
    chk("reload_state_end", 32'(st), 0);
    @(negedge clk);

    push(8'h43);
    chk("run_state", 32'(st), 2);
    chk("run_step1", 32'(step), 1);
    for (int k = 2; k <= 10; k++) begin
      if (k == 5) push(8'h45); else @(negedge clk);
      chk("run_step", 32'(step), 1);
    end
    chk("run_ignores_bytes", 32'(st), 2);
    halted = 1'b1;
    @(negedge clk);
    halted = 1'b0;
    chk("run_halt_step", 32'(step), 0);
    chk("run_halt_state", 32'(st), 0);
    @(negedge clk);
    chk("run_idle_step", 32'(step), 0);

    push(8'h53);
    chk("step_state", 32'(st), 3);
    chk("step_idle", 32'(step), 0);
    base = step_cnt;
    for (int n = 0; n < 3; n++) begin
      push(8'h4E);
      chk("step_pulse", 32'(step), 1);
      @(negedge clk);
      chk("step_single", 32'(step), 0);
      repeat (2) @(negedge clk);
    end
    push(8'h45);
    chk("step_exit_state", 32'(st), 0);
    chk("step_count", 32'(step_cnt - base), 3);
    push(8'h53);
    halted = 1'b1;
    push(8'h4E);
    halted = 1'b0;
    chk("step_halt_nopulse", 32'(step), 0);
    chk("step_halt_state", 32'(st), 0);
    @(negedge clk);
    chk("step_halt_after", 32'(step), 0);

    push(8'h4C); push(8'hAA); push(8'hBB);
    rst = 1'b0;
    #1;
    chk("abort_state", 32'(st), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(8'h4C); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("abort_pmw", 32'(pmw), 1);
    chk("abort_addr", 32'(waddr), 0);
    chk("abort_data", instr, 32'h0403_0201);
    push(8'h05); push(8'h06); push(8'h07); push(8'h08);
    chk("cancel_pre", 32'(pmw), 1);
    rst = 1'b0;
    #1;
    chk("cancel_pmw", 32'(pmw), 0);
    chk("cancel_addr", 32'(waddr), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("exclusive", 32'(both_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
